// File: rtl/controle_exibe_sequencia.sv
// Playback sequencer for the memory game: before each round it walks the
// sequence ROM from address 0 up to the latched round index. Each entry is
// lit for T_ON cycles and then kept dark for T_OFF cycles.
//
// All outputs are registered. Each output takes the value that belongs to the
// state being entered on the same edge, so the outputs always match the state.
//
// Handshakes (single level/pulse semantics):
//   iniciar  - level request, sampled only in ocioso; ignored elsewhere.
//   cancela  - synchronous abort, beats every transition, never yields pronto.
//   pronto   - one-cycle pulse while in fim, after the last gap completes.
// ROM timing: endereco already holds the next address in the cycle before
// carrega (ocioso or avanca). The synchronous ROM data is therefore valid
// during carrega and is captured into leds when carrega exits.
module controle_exibe_sequencia #(
  parameter int ADDR_W  = 4,
  parameter int TIMER_W = 16,
  parameter int T_ON    = 1000,
  parameter int T_OFF   = 500
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              cancela,
  input  logic [ADDR_W-1:0] rodada,
  input  logic [3:0]        dado_mem,
  output logic [ADDR_W-1:0] endereco,
  output logic [3:0]        leds,
  output logic              exibindo,
  output logic              pronto,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    OCIOSO  = 4'h0,
    CARREGA = 4'h1,
    ACENDE  = 4'h2,
    APAGA   = 4'h3,
    AVANCA  = 4'h4,
    FIM     = 4'hF
  } estado_t;

  localparam logic [TIMER_W-1:0] ULTIMO_ON  = TIMER_W'(T_ON - 1);
  localparam logic [TIMER_W-1:0] ULTIMO_OFF = TIMER_W'(T_OFF - 1);

  estado_t             estado;
  logic [TIMER_W-1:0]  timer;
  logic [ADDR_W-1:0]   rodada_reg;

  // State register plus all registered outputs, timer and latched round index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= OCIOSO;
      endereco   <= '0;
      leds       <= '0;
      exibindo   <= 1'b0;
      pronto     <= 1'b0;
      timer      <= '0;
      rodada_reg <= '0;
    end else if (cancela) begin
      // abort wins over everything, including a simultaneous iniciar
      estado   <= OCIOSO;
      endereco <= '0;
      leds     <= '0;
      exibindo <= 1'b0;
      pronto   <= 1'b0;
      timer    <= '0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          endereco <= '0;
          leds     <= '0;
          timer    <= '0;
          if (iniciar) begin
            estado     <= CARREGA;
            rodada_reg <= rodada;
            exibindo   <= 1'b1;
          end
        end
        CARREGA: begin
          // ROM output for endereco is valid now; capture it for display
          timer  <= '0;
          leds   <= dado_mem;
          estado <= ACENDE;
        end
        ACENDE: begin
          if (timer == ULTIMO_ON) begin
            timer  <= '0;
            leds   <= '0;
            estado <= APAGA;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        APAGA: begin
          if (timer == ULTIMO_OFF) begin
            timer <= '0;
            if (endereco == rodada_reg) begin
              estado   <= FIM;
              exibindo <= 1'b0;
              pronto   <= 1'b1;
            end else begin
              // advance early so the ROM read completes before carrega exits
              estado   <= AVANCA;
              endereco <= endereco + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        AVANCA: begin
          estado <= CARREGA;
        end
        FIM: begin
          estado   <= OCIOSO;
          endereco <= '0;
          leds     <= '0;
        end
        default: begin
          estado   <= OCIOSO;
          endereco <= '0;
          leds     <= '0;
          exibindo <= 1'b0;
          timer    <= '0;
        end
      endcase
    end
  end

  // Debug code: the state encoding itself, E for any undefined code
  always_comb begin
    db_estado = 4'hE;
    case (estado)
      OCIOSO, CARREGA, ACENDE, APAGA, AVANCA, FIM: db_estado = estado;
      default:                                     db_estado = 4'hE;
    endcase
  end

endmodule

// File: tb/tb_controle_exibe_sequencia.sv
// Directed bench for controle_exibe_sequencia with T_ON=4 and T_OFF=2.
// One playback entry takes 8 cycles counted from the start edge
// (carrega, 4x acende, 2x apaga, avanca/fim), so pronto lands at c = 8r+7.
module tb_controle_exibe_sequencia;

  localparam int ADDR_W  = 4;
  localparam int TIMER_W = 16;
  localparam int T_ON    = 4;
  localparam int T_OFF   = 2;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              iniciar = 1'b0;
  logic              cancela = 1'b0;
  logic [ADDR_W-1:0] rodada = '0;
  logic [3:0]        dado_mem = '0;
  logic [ADDR_W-1:0] endereco;
  logic [3:0]        leds;
  logic              exibindo;
  logic              pronto;
  logic [3:0]        db_estado;

  logic [3:0] rom [16];
  int n_cmp  = 0;
  int n_fail = 0;

  controle_exibe_sequencia #(
    .ADDR_W(ADDR_W), .TIMER_W(TIMER_W), .T_ON(T_ON), .T_OFF(T_OFF)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .cancela(cancela),
    .rodada(rodada), .dado_mem(dado_mem), .endereco(endereco), .leds(leds),
    .exibindo(exibindo), .pronto(pronto), .db_estado(db_estado)
  );

  // clock
  always #5 clock = ~clock;

  // synchronous sequence ROM, one-cycle read latency
  always @(posedge clock) dado_mem <= rom[endereco];

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // all outputs at their idle/reset values
  task automatic check_idle(input string tag);
    cmp({tag, " estado"},   8'(db_estado), 8'h0);
    cmp({tag, " leds"},     8'(leds),      8'h0);
    cmp({tag, " endereco"}, 8'(endereco),  8'h0);
    cmp({tag, " exibindo"}, 8'(exibindo),  8'h0);
    cmp({tag, " pronto"},   8'(pronto),    8'h0);
  endtask

  // expected outputs c cycles after the start edge for latched round r
  task automatic check_play(input int c, input int r);
    logic [3:0] e_st, e_leds, e_end;
    logic       e_pr, e_ex;
    int k, off;
    k = c / 8;
    off = c % 8;
    e_pr = 1'b0; e_ex = 1'b1; e_leds = 4'h0; e_end = 4'(k); e_st = 4'h0;
    if (c == 8 * r + 7) begin
      e_st = 4'hF; e_ex = 1'b0; e_pr = 1'b1; e_end = 4'(r);
    end else if (c > 8 * r + 7) begin
      e_st = 4'h0; e_ex = 1'b0; e_end = 4'h0;
    end else if (off == 0) begin
      e_st = 4'h1;
    end else if (off <= 4) begin
      e_st = 4'h2; e_leds = rom[k];
    end else if (off <= 6) begin
      e_st = 4'h3;
    end else begin
      e_st = 4'h4; e_end = 4'(k + 1);
    end
    cmp($sformatf("c%0d estado", c),   8'(db_estado), 8'(e_st));
    cmp($sformatf("c%0d leds", c),     8'(leds),      8'(e_leds));
    cmp($sformatf("c%0d endereco", c), 8'(endereco),  8'(e_end));
    cmp($sformatf("c%0d exibindo", c), 8'(exibindo),  8'(e_ex));
    cmp($sformatf("c%0d pronto", c),   8'(pronto),    8'(e_pr));
  endtask

  // pulse iniciar over one rising edge; returns at the negedge after it (c=0)
  task automatic start(input int r);
    @(negedge clock);
    rodada = 4'(r);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 4'h0;

    // reset state
    repeat (2) @(negedge clock);
    check_idle("reset");
    reset = 1'b0;
    @(negedge clock);
    check_idle("after_reset");

    // test 1: single entry, rodada=0
    rom[0] = 4'b0010;
    start(0);
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 0);
    end

    // tests 2+3: three entries; rodada changed and iniciar pulsed mid-acende
    rom[0] = 4'b0001; rom[1] = 4'b0100; rom[2] = 4'b1000;
    start(2);
    for (int c = 0; c <= 25; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 2);
      if (c == 2) begin rodada = 4'd0; iniciar = 1'b1; end
      if (c == 3) iniciar = 1'b0;
    end

    // test 4: cancela in apaga at endereco=1, then replay from address 0
    start(2);
    for (int c = 0; c <= 13; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 2);
    end
    cancela = 1'b1;
    @(negedge clock);
    cancela = 1'b0;
    check_idle("cancela");
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      cmp($sformatf("cancela_quiet%0d pronto", i), 8'(pronto), 8'h0);
    end
    start(1);
    for (int c = 0; c <= 17; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 1);
    end

    // test 5: asynchronous reset mid-acende, no clock edge involved
    start(0);
    for (int c = 0; c <= 2; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 0);
    end
    #2 reset = 1'b1;
    #1 check_idle("async_reset");
    @(negedge clock);
    reset = 1'b0;
    start(0);
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 0);
    end

    // test 6: iniciar and cancela together hold ocioso
    @(negedge clock);
    rodada = 4'd0;
    iniciar = 1'b1;
    cancela = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      cmp($sformatf("both%0d estado", i),   8'(db_estado), 8'h0);
      cmp($sformatf("both%0d exibindo", i), 8'(exibindo),  8'h0);
    end
    cancela = 1'b0;
    @(negedge clock);
    iniciar = 1'b0;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clock);
      check_play(c, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
